// File: rtl/cam_tag_pkg.sv
// Shared encodings for the CAM tag resolver: compare operations and resolver states.
package cam_tag_pkg;

    typedef enum logic [1:0] {
        CMP_LOAD  = 2'b00,
        CMP_AND   = 2'b01,
        CMP_OR    = 2'b10,
        CMP_CLEAR = 2'b11
    } cmp_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EMIT = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/cam_tag_prio_enc.sv
// Lowest-set-bit encoder: index of the least significant set bit plus an any flag.
module cam_tag_prio_enc #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic [WIDTH-1:0]      vec,
    output logic [ADDR_WIDTH-1:0] idx_c,
    output logic                  any_c
);

    // Scan from the top down so the lowest set bit is the last to win.
    always_comb begin
        idx_c = '0;
        any_c = 1'b0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx_c = ADDR_WIDTH'(i);
                any_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cam_tag_resolver.sv
// Persistent tag register across compare passes plus a lowest-first multi-match resolver.
// Optional feature macro: CAM_TAG_MATCH_COUNT_EN adds a combinational match_count output.
module cam_tag_resolver
    import cam_tag_pkg::*;
#(
    parameter int unsigned DATA_DEPTH     = 16,
    parameter int unsigned ADDR_WIDTH_CAM = 8
) (
    input  logic                      clk,
    input  logic                      rstIn,
    input  logic [DATA_DEPTH-1:0]     tag_row,
    input  logic                      cmp_valid,
    input  logic [1:0]                cmp_op,
    output logic                      cmp_drop,
    output logic [DATA_DEPTH-1:0]     tag,
    output logic                      tag_any,
    output logic [ADDR_WIDTH_CAM-1:0] first_addr,
    input  logic                      res_start,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [ADDR_WIDTH_CAM-1:0] res_addr,
    output logic                      res_last,
    output logic                      res_done,
    output logic                      busy
`ifdef CAM_TAG_MATCH_COUNT_EN
    ,
    output logic [$clog2(DATA_DEPTH+1)-1:0] match_count
`endif
);

    localparam int unsigned CNT_WIDTH = $clog2(DATA_DEPTH + 1);

    state_e                    state_q, state_d;
    logic [DATA_DEPTH-1:0]     tag_q, tag_d, scan_q, scan_d;
    logic [DATA_DEPTH-1:0]     tag_op_c, next_tag_c, scan_src_c;
    logic                      res_valid_q, res_valid_d;
    logic [ADDR_WIDTH_CAM-1:0] res_addr_q, res_addr_d;
    logic                      res_last_q, res_last_d;
    logic                      res_done_q, res_done_d;
    logic                      cmp_drop_q, cmp_drop_d;
    logic [ADDR_WIDTH_CAM-1:0] scan_idx_c;
    logic                      scan_any_c;
    logic                      scan_single_c;

    cam_tag_prio_enc #(.WIDTH(DATA_DEPTH), .ADDR_WIDTH(ADDR_WIDTH_CAM)) u_first_enc (
        .vec   (tag_q),
        .idx_c (first_addr),
        .any_c (tag_any)
    );

    // In IDLE the scan path looks at the tag about to be resolved; in EMIT at scan minus the accepted bit.
    cam_tag_prio_enc #(.WIDTH(DATA_DEPTH), .ADDR_WIDTH(ADDR_WIDTH_CAM)) u_scan_enc (
        .vec   (scan_src_c),
        .idx_c (scan_idx_c),
        .any_c (scan_any_c)
    );

    always_comb begin
        tag_op_c = tag_q;
        case (cmp_op_e'(cmp_op))
            CMP_LOAD:  tag_op_c = tag_row;
            CMP_AND:   tag_op_c = tag_q & tag_row;
            CMP_OR:    tag_op_c = tag_q | tag_row;
            CMP_CLEAR: tag_op_c = '0;
            default:   tag_op_c = tag_q;
        endcase
        next_tag_c = cmp_valid ? tag_op_c : tag_q;
    end

    always_comb begin
        scan_src_c = next_tag_c;
        if (state_q != ST_IDLE) begin
            scan_src_c = scan_q & ~(DATA_DEPTH'(1) << res_addr_q);
        end
        scan_single_c = scan_any_c && ((scan_src_c & (scan_src_c - DATA_DEPTH'(1))) == '0);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        scan_d      = scan_q;
        res_valid_d = res_valid_q;
        res_addr_d  = res_addr_q;
        res_last_d  = res_last_q;
        res_done_d  = 1'b0;
        cmp_drop_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmp_valid) begin
                    tag_d = tag_op_c;
                end
                if (res_start) begin
                    scan_d = next_tag_c;
                    if (scan_any_c) begin
                        state_d     = ST_EMIT;
                        res_valid_d = 1'b1;
                        res_addr_d  = scan_idx_c;
                        res_last_d  = scan_single_c;
                    end else begin
                        state_d    = ST_DONE;
                        res_done_d = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                cmp_drop_d = cmp_valid;
                if (res_valid_q && res_ready) begin
                    scan_d = scan_src_c;
                    if (res_last_q) begin
                        state_d     = ST_DONE;
                        res_valid_d = 1'b0;
                        res_last_d  = 1'b0;
                        res_addr_d  = '0;
                        res_done_d  = 1'b1;
                    end else begin
                        res_addr_d = scan_idx_c;
                        res_last_d = scan_single_c;
                    end
                end
            end
            ST_DONE: begin
                cmp_drop_d = cmp_valid;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstIn) begin
        if (!rstIn) begin
            state_q     <= ST_IDLE;
            tag_q       <= '0;
            scan_q      <= '0;
            res_valid_q <= 1'b0;
            res_addr_q  <= '0;
            res_last_q  <= 1'b0;
            res_done_q  <= 1'b0;
            cmp_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            scan_q      <= scan_d;
            res_valid_q <= res_valid_d;
            res_addr_q  <= res_addr_d;
            res_last_q  <= res_last_d;
            res_done_q  <= res_done_d;
            cmp_drop_q  <= cmp_drop_d;
        end
    end

    assign tag       = tag_q;
    assign res_valid = res_valid_q;
    assign res_addr  = res_addr_q;
    assign res_last  = res_last_q;
    assign res_done  = res_done_q;
    assign cmp_drop  = cmp_drop_q;
    assign busy      = (state_q != ST_IDLE);

`ifdef CAM_TAG_MATCH_COUNT_EN
    always_comb begin
        match_count = '0;
        for (int i = 0; i < int'(DATA_DEPTH); i++) begin
            match_count = match_count + CNT_WIDTH'(tag_q[i]);
        end
    end
`endif

endmodule

// File: tb/tb_cam_tag_resolver.sv
// Directed self-checking bench for cam_tag_resolver with hand-computed expectations.
module tb_cam_tag_resolver;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 8;

    logic             clk = 1'b0;
    logic             rstIn;
    logic [DEPTH-1:0] tag_row;
    logic             cmp_valid;
    logic [1:0]       cmp_op;
    logic             cmp_drop;
    logic [DEPTH-1:0] tag;
    logic             tag_any;
    logic [AW-1:0]    first_addr;
    logic             res_start;
    logic             res_valid;
    logic             res_ready;
    logic [AW-1:0]    res_addr;
    logic             res_last;
    logic             res_done;
    logic             busy;
`ifdef CAM_TAG_MATCH_COUNT_EN
    logic [$clog2(DEPTH+1)-1:0] match_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cam_tag_resolver #(.DATA_DEPTH(DEPTH), .ADDR_WIDTH_CAM(AW)) dut (
        .clk        (clk),
        .rstIn      (rstIn),
        .tag_row    (tag_row),
        .cmp_valid  (cmp_valid),
        .cmp_op     (cmp_op),
        .cmp_drop   (cmp_drop),
        .tag        (tag),
        .tag_any    (tag_any),
        .first_addr (first_addr),
        .res_start  (res_start),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_addr   (res_addr),
        .res_last   (res_last),
        .res_done   (res_done),
        .busy       (busy)
`ifdef CAM_TAG_MATCH_COUNT_EN
        ,
        .match_count(match_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input logic [1:0] op, input logic [DEPTH-1:0] row);
        cmp_valid = 1'b1;
        cmp_op    = op;
        tag_row   = row;
        tick();
        cmp_valid = 1'b0;
    endtask

    task automatic start();
        res_start = 1'b1;
        tick();
        res_start = 1'b0;
    endtask

    initial begin
        rstIn     = 1'b0;
        tag_row   = '0;
        cmp_valid = 1'b0;
        cmp_op    = 2'b00;
        res_start = 1'b0;
        res_ready = 1'b0;
        tick();
        tick();
        check("rst_tag", 32'(tag), 32'h0);
        check("rst_valid", 32'(res_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(res_done), 32'h0);
        check("rst_drop", 32'(cmp_drop), 32'h0);
        @(negedge clk);
        rstIn = 1'b1;
        tick();

        // Multi-pass combine
        cmp(2'b00, 16'hF0F0);
        check("load_tag", 32'(tag), 32'hF0F0);
        check("load_first", 32'(first_addr), 32'd4);
        cmp(2'b01, 16'h3C3C);
        check("and_tag", 32'(tag), 32'h3030);
        cmp(2'b10, 16'h0001);
        check("or_tag", 32'(tag), 32'h3031);
        check("or_any", 32'(tag_any), 32'h1);
        check("or_first", 32'(first_addr), 32'd0);

        // Streaming resolution with ready held high
        cmp(2'b00, 16'h8011);
        res_ready = 1'b1;
        start();
        check("r3_v0", 32'(res_valid), 32'h1);
        check("r3_a0", 32'(res_addr), 32'd0);
        check("r3_l0", 32'(res_last), 32'h0);
        check("r3_busy", 32'(busy), 32'h1);
        tick();
        check("r3_a1", 32'(res_addr), 32'd4);
        check("r3_l1", 32'(res_last), 32'h0);
        tick();
        check("r3_a2", 32'(res_addr), 32'd15);
        check("r3_l2", 32'(res_last), 32'h1);
        tick();
        check("r3_vend", 32'(res_valid), 32'h0);
        check("r3_done", 32'(res_done), 32'h1);
        tick();
        check("r3_done_pulse", 32'(res_done), 32'h0);
        check("r3_idle", 32'(busy), 32'h0);
        check("r3_tag_kept", 32'(tag), 32'h8011);

        // Backpressure
        cmp(2'b00, 16'h0006);
        res_ready = 1'b0;
        start();
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", 32'(res_valid), 32'h1);
            check("bp_addr", 32'(res_addr), 32'd1);
            check("bp_last", 32'(res_last), 32'h0);
            if (i < 2) tick();
        end
        res_ready = 1'b1;
        tick();
        check("bp_addr2", 32'(res_addr), 32'd2);
        check("bp_last2", 32'(res_last), 32'h1);
        tick();
        check("bp_done", 32'(res_done), 32'h1);
        tick();

        // Empty tag
        cmp(2'b11, 16'hFFFF);
        check("clr_tag", 32'(tag), 32'h0);
        check("clr_any", 32'(tag_any), 32'h0);
        check("clr_first", 32'(first_addr), 32'd0);
        start();
        check("empty_valid", 32'(res_valid), 32'h0);
        check("empty_done", 32'(res_done), 32'h1);
        tick();
        check("empty_done_pulse", 32'(res_done), 32'h0);
        check("empty_idle", 32'(busy), 32'h0);

        // Compare collision while busy
        cmp(2'b00, 16'h0030);
        res_ready = 1'b0;
        start();
        check("col_addr", 32'(res_addr), 32'd4);
        cmp(2'b00, 16'h0003);
        check("col_drop", 32'(cmp_drop), 32'h1);
        check("col_tag", 32'(tag), 32'h0030);
        tick();
        check("col_drop_pulse", 32'(cmp_drop), 32'h0);
        res_start = 1'b1;
        res_ready = 1'b1;
        tick();
        res_start = 1'b0;
        check("col_addr5", 32'(res_addr), 32'd5);
        check("col_last5", 32'(res_last), 32'h1);
        tick();
        check("col_done", 32'(res_done), 32'h1);
        tick();
        check("col_idle", 32'(busy), 32'h0);

        // Same-cycle compare and start
        cmp_valid = 1'b1;
        cmp_op    = 2'b00;
        tag_row   = 16'h0100;
        res_ready = 1'b0;
        res_start = 1'b1;
        tick();
        cmp_valid = 1'b0;
        res_start = 1'b0;
        check("same_valid", 32'(res_valid), 32'h1);
        check("same_addr", 32'(res_addr), 32'd8);
        check("same_last", 32'(res_last), 32'h1);
        check("same_tag", 32'(tag), 32'h0100);
`ifdef CAM_TAG_MATCH_COUNT_EN
        check("same_count", 32'(match_count), 32'd1);
`endif
        res_ready = 1'b1;
        tick();
        check("same_done", 32'(res_done), 32'h1);
        tick();

        // All-ones tag reaches the top row
        cmp(2'b00, 16'hFFFF);
`ifdef CAM_TAG_MATCH_COUNT_EN
        check("ones_count", 32'(match_count), 32'd16);
`endif
        start();
        for (int i = 0; i < 16; i++) begin
            check("ones_addr", 32'(res_addr), 32'(i));
            check("ones_last", 32'(res_last), (i == 15) ? 32'h1 : 32'h0);
            tick();
        end
        check("ones_done", 32'(res_done), 32'h1);
        tick();

        // Reset in the middle of a resolution
        cmp(2'b00, 16'h0005);
        res_ready = 1'b0;
        start();
        check("mid_valid", 32'(res_valid), 32'h1);
        @(negedge clk);
        rstIn = 1'b0;
        #1;
        check("mrst_tag", 32'(tag), 32'h0);
        check("mrst_valid", 32'(res_valid), 32'h0);
        check("mrst_busy", 32'(busy), 32'h0);
        check("mrst_done", 32'(res_done), 32'h0);
        tick();
        rstIn = 1'b1;
        tick();
        check("mrst_no_done", 32'(res_done), 32'h0);
        check("mrst_no_valid", 32'(res_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
